// File: rtl/posit_pipe_defines.sv
// Shared constants and stage-register types for the pipelined posit sum normaliser.
package posit_pipe_defines;

  localparam int unsigned NBITS   = 32;
  localparam int unsigned ES      = 3;
  localparam int unsigned SCALE_W = 9;
  localparam int unsigned FRAC_W  = 30;
  localparam int unsigned SER_W   = 1 + SCALE_W + FRAC_W + 2;
  localparam int unsigned SHIFT_W = $clog2(2 * NBITS);

  typedef struct packed {
    logic                      sgn;
    logic signed [SCALE_W-1:0] scale;
    logic [FRAC_W-1:0]         fraction;
    logic                      inf;
    logic                      zero;
  } value_ser_t;

  typedef struct packed {
    logic               sgn;
    logic               scale_neg;
    logic [SHIFT_W-1:0] r;
    logic [ES-1:0]      exp;
    logic [FRAC_W-1:0]  fraction;
    logic               inf;
    logic               zero;
    logic               sticky_in;
`ifdef POSIT_NORM_SATURATE_EN
    logic               ovf;
`endif
  } s1_t;

  typedef struct packed {
    logic             sgn;
    logic [NBITS-2:0] body;
    logic             guard;
    logic             sticky;
    logic             inf;
    logic             zero;
`ifdef POSIT_NORM_SATURATE_EN
    logic             ovf;
`endif
  } s2_t;

endpackage

// File: rtl/posit_regime_shifter.sv
// Combinational regime/exponent/fraction packer: yields the posit body plus guard and sticky.
module posit_regime_shifter #(
  parameter int unsigned NBITS   = 32,
  parameter int unsigned ES      = 3,
  parameter int unsigned FRAC_W  = 30,
  parameter int unsigned SHIFT_W = $clog2(2 * NBITS)
) (
  input  logic               scale_neg,
  input  logic [SHIFT_W-1:0] r,
  input  logic [ES-1:0]      exp,
  input  logic [FRAC_W-1:0]  fraction,
  output logic [NBITS-2:0]   body,
  output logic               guard,
  output logic               sticky
);

  // Wide enough that even the longest regime pushes no payload bit off the bottom.
  localparam int unsigned VEC_W = NBITS + ES + FRAC_W;

  logic [VEC_W-1:0] tail_vec, fill, shifted;

  always_comb begin
    tail_vec = {scale_neg, exp, fraction, {(NBITS - 1){1'b0}}};
    // The r vacated top positions become the regime run (ones for scale >= 0).
    fill     = ~({VEC_W{1'b1}} >> r);
    shifted  = (tail_vec >> r) | (fill & {VEC_W{~scale_neg}});
    body     = shifted[VEC_W-1 -: NBITS-1];
    guard    = shifted[VEC_W-NBITS];
    sticky   = |shifted[VEC_W-NBITS-1:0];
  end

endmodule

// File: rtl/posit_normalize_pipe.sv
// 3-stage valid/ready posit normaliser with round-to-nearest-even.
// Define POSIT_NORM_SATURATE_EN to clamp oversized scales / rounding carries to maxpos.
module posit_normalize_pipe
  import posit_pipe_defines::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SER_W-1:0] in_data,
  input  logic             in_truncated,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NBITS-1:0] out_result,
  output logic             out_inf,
  output logic             out_zero
);

`ifdef POSIT_NORM_SATURATE_EN
  localparam int MAX_SCALE = int'((NBITS - 2) << ES);
`endif

  value_ser_t in_v;
  s1_t        s1_d, s1_q;
  s2_t        s2_d, s2_q;
  logic       v1_q, v2_q;
  logic       adv1, adv2, adv3;

  logic signed [SCALE_W-1:0] k;
  logic [SCALE_W-1:0]        r_raw;
  logic [NBITS-2:0]          sh_body;
  logic                      sh_guard, sh_sticky;
  logic                      round_up, carry;
  logic [NBITS-2:0]          rounded, mag, body_out;
  logic [NBITS-1:0]          res_d;

  assign in_v     = in_data;
  assign adv3     = ~out_valid | out_ready;
  assign adv2     = ~v2_q | adv3;
  assign adv1     = ~v1_q | adv2;
  assign in_ready = adv1;

  // S1: regime run length from the scale.
  always_comb begin
    k               = in_v.scale >>> ES;
    r_raw           = in_v.scale[SCALE_W-1] ? -k : k + SCALE_W'(1);
    s1_d.sgn        = in_v.sgn;
    s1_d.scale_neg  = in_v.scale[SCALE_W-1];
    s1_d.r          = (r_raw > SCALE_W'(NBITS - 1)) ? SHIFT_W'(NBITS - 1) : r_raw[SHIFT_W-1:0];
    s1_d.exp        = in_v.scale[ES-1:0];
    s1_d.fraction   = in_v.fraction;
    s1_d.inf        = in_v.inf;
    s1_d.zero       = in_v.zero;
    s1_d.sticky_in  = in_truncated;
`ifdef POSIT_NORM_SATURATE_EN
    s1_d.ovf        = in_v.scale > SCALE_W'(MAX_SCALE);
`endif
  end

  posit_regime_shifter #(
    .NBITS  (NBITS),
    .ES     (ES),
    .FRAC_W (FRAC_W),
    .SHIFT_W(SHIFT_W)
  ) u_shifter (
    .scale_neg(s1_q.scale_neg),
    .r        (s1_q.r),
    .exp      (s1_q.exp),
    .fraction (s1_q.fraction),
    .body     (sh_body),
    .guard    (sh_guard),
    .sticky   (sh_sticky)
  );

  // S2: capture shifted body with guard/sticky.
  always_comb begin
    s2_d.sgn    = s1_q.sgn;
    s2_d.body   = sh_body;
    s2_d.guard  = sh_guard;
    s2_d.sticky = sh_sticky | s1_q.sticky_in;
    s2_d.inf    = s1_q.inf;
    s2_d.zero   = s1_q.zero;
`ifdef POSIT_NORM_SATURATE_EN
    s2_d.ovf    = s1_q.ovf;
`endif
  end

  // S3: round to nearest even, keep magnitude >= minpos, apply sign.
  always_comb begin
    round_up         = s2_q.guard & (s2_q.sticky | s2_q.body[0]);
    {carry, rounded} = {1'b0, s2_q.body} + NBITS'(round_up);
    mag              = (rounded == '0) ? {{(NBITS - 2){1'b0}}, 1'b1} : rounded;
`ifdef POSIT_NORM_SATURATE_EN
    if (carry || s2_q.ovf) mag = '1;
`else
    if (carry) mag = '0;
`endif
    body_out = s2_q.sgn ? -mag : mag;
    if (s2_q.inf) begin
      res_d = {1'b1, {(NBITS - 1){1'b0}}};
    end else if (s2_q.zero) begin
      res_d = '0;
    end else begin
      res_d = {s2_q.sgn, body_out};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_inf    <= 1'b0;
      out_zero   <= 1'b0;
    end else begin
      if (adv1) v1_q <= in_valid;
      if (adv2) v2_q <= v1_q;
      if (adv3) out_valid <= v2_q;
      if (adv3 && v2_q) begin
        out_result <= res_d;
        out_inf    <= s2_q.inf;
        out_zero   <= s2_q.zero & ~s2_q.inf;
      end
    end
  end

  // Payload registers need no reset; their valids gate every use.
  always_ff @(posedge clk) begin
    if (adv1 && in_valid) s1_q <= s1_d;
    if (adv2 && v1_q) s2_q <= s2_d;
  end

endmodule
